// File: rtl/exe_mul_sequencer.sv
// exe_mul_sequencer: multi-cycle radix-2 shift-add MUL controller for the
// scalar execute stage. It retires one multiplier bit per cycle, returns the
// low XLEN bits of the product, stalls the pipeline while busy and aborts on
// a branch/jump flush.
// Optional build macro: MUL_EARLY_EXIT_EN. When it is defined, BUSY ends as
// soon as the remaining multiplier bits are exhausted. The result is
// identical either way; only the latency changes.

`ifndef ALU_OP_W
`define ALU_OP_W 8
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 8'h01
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL 8'h0c
`endif

module exe_mul_sequencer #(
  parameter int unsigned XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  input  logic [`ALU_OP_W-1:0] alu_opcode_i,
  input  logic [XLEN-1:0]      operand_rs1_i,
  input  logic [XLEN-1:0]      operand_rs2_i,
  input  logic [4:0]           rd_addr_i,
  output logic                 req_ready_o,
  input  logic                 flush_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [XLEN-1:0]      resp_result_o,
  output logic [4:0]           resp_rd_o,
  output logic                 stall_o,
  output logic                 busy_o
);

  // Iteration counter width, derived from XLEN.
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [4:0]      rd_q;
  logic            accept;
  logic            last_step;

  // Request handshake: only a MUL arriving in IDLE without a flush is taken.
  always_comb begin
    accept = req_valid_i & (state == S_IDLE) &
             (alu_opcode_i == `ALU_OP_MUL) & ~flush_i;
  end

  // Decide whether the current BUSY cycle is the final iteration.
`ifdef MUL_EARLY_EXIT_EN
  // Finishing when at most the low multiplier bit remains covers both an
  // already-zero multiplier and one that becomes zero after this step, which
  // gives max(1, msb index + 1) BUSY cycles.
  always_comb begin
    last_step = (cnt == CNT_W'(XLEN - 1)) | (mplier[XLEN-1:1] == '0);
  end
`else
  always_comb begin
    last_step = (cnt == CNT_W'(XLEN - 1));
  end
`endif

  // Pipeline stall: asserted from the accept cycle until the result is taken.
  always_comb begin
    stall_o = accept | (state == S_BUSY) | ((state == S_DONE) & ~resp_ready_i);
  end

  // Result and rd are only presented while the response is valid.
  always_comb begin
    resp_result_o = resp_valid_o ? acc  : '0;
    resp_rd_o     = resp_valid_o ? rd_q : '0;
  end

  // Controller FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      cnt          <= '0;
      rd_q         <= '0;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      resp_valid_o <= 1'b0;
    end else if (flush_i) begin
      state        <= S_IDLE;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      resp_valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc         <= '0;
            mcand       <= operand_rs1_i;
            mplier      <= operand_rs2_i;
            cnt         <= '0;
            rd_q        <= rd_addr_i;
            state       <= S_BUSY;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        S_BUSY: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            state        <= S_DONE;
            resp_valid_o <= 1'b1;
          end
        end
        S_DONE: begin
          if (resp_ready_i) begin
            state        <= S_IDLE;
            resp_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          resp_valid_o <= 1'b0;
          busy_o       <= 1'b0;
          req_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// Scoreboard bench for exe_mul_sequencer: the driver pushes the expected
// product/rd/latency on every accept, a negedge monitor compares outputs
// every cycle and pops the entry when the response is taken.

`ifndef ALU_OP_W
`define ALU_OP_W 8
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 8'h01
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL 8'h0c
`endif

module tb_exe_mul_sequencer;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req_valid_i;
  logic [`ALU_OP_W-1:0] alu_opcode_i;
  logic [63:0]          operand_rs1_i;
  logic [63:0]          operand_rs2_i;
  logic [4:0]           rd_addr_i;
  logic                 req_ready_o;
  logic                 flush_i;
  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [63:0]          resp_result_o;
  logic [4:0]           resp_rd_o;
  logic                 stall_o;
  logic                 busy_o;

  exe_mul_sequencer #(.XLEN(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .alu_opcode_i  (alu_opcode_i),
    .operand_rs1_i (operand_rs1_i),
    .operand_rs2_i (operand_rs2_i),
    .rd_addr_i     (rd_addr_i),
    .req_ready_o   (req_ready_o),
    .flush_i       (flush_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_result_o (resp_result_o),
    .resp_rd_o     (resp_rd_o),
    .stall_o       (stall_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    logic [4:0]  rd;
    int unsigned t;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned passes = 0;
  bit          accept_now = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
  endtask

  // Number of BUSY cycles the operation should take.
  function automatic int unsigned exp_lat(input logic [63:0] m);
    int unsigned l;
    l = 64;
`ifdef MUL_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < 64; i++) if (m[i]) l = i + 1;
`endif
    return l;
  endfunction

  // Monitor: after the driver has set this cycle's inputs, compare outputs
  // against the phase implied by the in-flight scoreboard entry.
  always @(negedge clk) begin
    #1;
    if (cyc > 0) begin
      bit          inflight, ev, eb, es;
      logic [63:0] er;
      logic [4:0]  erd;
      exp_t        e;
      inflight = (sb.size() != 0);
      ev = 1'b0; eb = 1'b0; es = 1'b0; er = '0; erd = '0;
      if (inflight) begin
        e  = sb[0];
        eb = (cyc > e.t);
        ev = (cyc >= e.t + e.lat + 1);
        es = (cyc == e.t) || (eb && !ev) || (ev && !resp_ready_i);
        if (ev) begin
          er  = e.prod;
          erd = e.rd;
        end
      end
      chk("resp_valid", 64'(resp_valid_o), 64'(ev));
      chk("busy",       64'(busy_o),       64'(eb));
      chk("req_ready",  64'(req_ready_o),  64'(!eb));
      chk("stall",      64'(stall_o),      64'(es));
      chk("result",     resp_result_o,     er);
      chk("rd",         64'(resp_rd_o),    64'(erd));
      if (!rst_n || flush_i) sb.delete();
      else if (ev && resp_ready_i) void'(sb.pop_front());
    end
  end

  task automatic bound_fail(input string name);
    checks++;
    $display("FAIL %s cyc=%0d actual=timeout expected=event", name, cyc);
  endtask

  // Present one request for a single cycle; record an expectation on accept.
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [`ALU_OP_W-1:0] op);
    exp_t e;
    @(negedge clk);
    req_valid_i   = 1'b1;
    alu_opcode_i  = op;
    operand_rs1_i = a;
    operand_rs2_i = b;
    rd_addr_i     = rd;
    if (sb.size() == 0 && op == `ALU_OP_MUL && !flush_i && rst_n) begin
      e.prod = a * b;
      e.rd   = rd;
      e.t    = cyc;
      e.lat  = exp_lat(b);
      sb.push_back(e);
      accept_now = 1'b1;
    end else begin
      accept_now = 1'b0;
    end
    @(negedge clk);
    accept_now    = 1'b0;
    req_valid_i   = 1'b0;
    flush_i       = 1'b0;
    operand_rs1_i = {$urandom, $urandom};
    operand_rs2_i = {$urandom, $urandom};
  endtask

  // Wait until no operation is in flight; optionally jiggle inputs meanwhile.
  task automatic wait_idle(input bit rnd);
    int unsigned n;
    n = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        req_valid_i  = 1'b0;
        flush_i      = 1'b0;
        resp_ready_i = 1'b1;
        break;
      end
      if (rnd) begin
        resp_ready_i  = ($urandom_range(0, 3) != 0);
        flush_i       = ($urandom_range(0, 99) == 0);
        req_valid_i   = $urandom_range(0, 1);
        alu_opcode_i  = `ALU_OP_MUL;
        operand_rs1_i = {$urandom, $urandom};
      end
      n++;
      if (n > 400) begin
        bound_fail("wait_idle");
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned t0, n;
    logic [63:0] a, b;
    rst_n = 1'b0; req_valid_i = 1'b0; alu_opcode_i = '0; operand_rs1_i = '0;
    operand_rs2_i = '0; rd_addr_i = '0; flush_i = 1'b0; resp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic product with immediate take.
    issue(64'd3, 64'd5, 5'd7, `ALU_OP_MUL);
    wait_idle(1'b0);
    // Wrap-around with carry dropped.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd9, `ALU_OP_MUL);
    wait_idle(1'b0);

    // Flush ten cycles after accept.
    issue(64'd123, 64'hFFFF_0000_0000_0001, 5'd3, `ALU_OP_MUL);
    t0 = sb.size() != 0 ? sb[0].t : cyc;
    while (cyc < t0 + 10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    repeat (3) @(negedge clk);

    // Hold the result for three DONE cycles before taking it.
    resp_ready_i = 1'b0;
    issue(64'hDEAD_BEEF, 64'h1234_5678_9ABC, 5'd31, `ALU_OP_MUL);
    n = 0;
    while (sb.size() != 0 && cyc < sb[0].t + sb[0].lat + 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bound_fail("reach_done");
    repeat (2) @(negedge clk);
    @(negedge clk);
    resp_ready_i = 1'b1;
    wait_idle(1'b0);

    // Non-MUL opcode is ignored.
    issue(64'd10, 64'd20, 5'd4, `ALU_OP_ADD);
    repeat (2) @(negedge clk);

    // Reset in the middle of BUSY.
    issue(64'd99, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, `ALU_OP_MUL);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Short multipliers (early-exit cases when enabled).
    issue(64'd7, 64'd3, 5'd1, `ALU_OP_MUL);
    wait_idle(1'b0);
    issue(64'hABCD, 64'd0, 5'd2, `ALU_OP_MUL);
    wait_idle(1'b0);
    issue(64'd0, 64'h8000_0000_0000_0000, 5'd5, `ALU_OP_MUL);
    wait_idle(1'b0);

    // Randomized traffic with random back-pressure, flushes and ADD noise.
    for (int unsigned k = 0; k < 40; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) b = '0;
      flush_i = ($urandom_range(0, 9) == 0);
      issue(a, b, 5'($urandom_range(0, 31)),
            ($urandom_range(0, 5) == 0) ? `ALU_OP_ADD : `ALU_OP_MUL);
      wait_idle(1'b1);
    end

    resp_ready_i = 1'b1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
